alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001: Parameter BASE_ADR, default 32'h3000_0000, Wishbone base address; decode on wbs_adr_i[31:8]==BASE_ADR[31:8], offset wbs_adr_i[7:0].
REQ-002: wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-003: wb_rst_i  in  1  reset, synchronous, active-high.
REQ-004: wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write.
REQ-005: wbs_sel_i  in  4  byte enables; wbs_adr_i  in  32  address; wbs_dat_i  in  32  write data.
REQ-006: wbs_ack_o  out  1  ack; wbs_dat_o  out  32  read data.
REQ-007: la_req_i  in  1  logic-analyzer requester level request; la_op_i  in  4, la_a_i  in  32, la_b_i  in  32  its operation/operands.
REQ-008: la_ack_o  out  1  one-cycle completion pulse; la_result_o  out  32  LA result register.
REQ-009: alu_op_o  out  4, alu_a_o  out  32, alu_b_o  out  32  registered drive to shared combinational ALU; alu_y_i  in  32  ALU result.
REQ-010: irq_o  out  1  user interrupt.

Function
REQ-011: Register map (offsets): 0x00 A (RW), 0x04 B (RW), 0x08 CMD (W: op=dat[3:0], triggers WB job; R: op), 0x0C RESULT (RO), 0x10 STATUS (bit0 busy RO, bit1 done W1C, bit2 ovf W1C, bit3 irq_en RW).
REQ-012: A/B writes honour wbs_sel_i per byte; CMD/STATUS writes use byte 0 only when wbs_sel_i[0]=1.
REQ-013: wbs_ack_o asserts one cycle after a decoded stb&cyc cycle, for exactly one cycle; never two consecutive cycles; undecoded addresses never acked.
REQ-014: Unmapped offsets inside the decoded window: acked, read 0, write ignored.
REQ-015: CMD write when WB job idle sets wb_pend and clears done; CMD write while wb_pend or WB job in flight is dropped and sets ovf.
REQ-016: busy = wb_pend OR WB job in flight.
REQ-017: LA eligible = la_req_i AND NOT la_ack_o AND no LA job in flight; LA requester holds operands stable until la_ack_o.
REQ-018: FSM states IDLE, EXEC, CAPT; IDLE->EXEC on grant, EXEC->CAPT unconditionally, CAPT->IDLE unconditionally.
REQ-019: At IDLE edge with grant: alu_op_o/alu_a_o/alu_b_o load from granted source (WB: CMD op, A, B; LA: la_op_i, la_a_i, la_b_i); wb_pend clears if WB granted.
REQ-020: Arbitration: single eligible requester granted; both eligible -> grant the one not granted last (round-robin); last_grant updates on each grant.
REQ-021: At CAPT edge: alu_y_i captured into RESULT (WB) and done set, or into la_result_o with la_ack_o=1 next cycle (LA).
REQ-022: Latency: grant edge k, capture edge k+2, la_ack_o/done visible cycle after k+2; next grant no earlier than edge k+3; max throughput one job per 3 cycles.
REQ-023: alu_*_o hold last values while IDLE.
REQ-024: irq_o = done AND irq_en (registered state, combinational OR-free).
REQ-025: Simultaneous CMD write and STATUS done-clear in one cycle impossible (single bus); done set by capture wins over W1C in same cycle.

Reset
REQ-026: On wb_rst_i: FSM IDLE, A/B/CMD/RESULT/la_result_o/alu_*_o = 0, wb_pend/done/ovf/irq_en = 0, wbs_ack_o/la_ack_o/irq_o = 0, last_grant = LA (first tie goes to WB).
REQ-027: Reset mid-job drops job silently: no la_ack_o, no done after reset release.

Verification
REQ-028: WB writes A=5, B=3, CMD op=0 with ALU model add -> RESULT reads 8, STATUS=0x2, alu_*_o change once.
REQ-029: la_req_i=1, op=1, a=10, b=4 (sub model) -> la_ack_o single pulse 3 cycles after request edge, la_result_o=6; la_req_i held one cycle past ack causes no second grant.
REQ-030: WB pend and la_req_i eligible same edge after reset -> WB granted first, LA next at k+3; repeat tie -> alternates.
REQ-031: Second CMD write while busy -> ovf=1, single completion, RESULT from first op; W1C of bit2 clears ovf.
REQ-032: irq_en=1, job completes -> irq_o=1; W1C done -> irq_o=0 next cycle.
REQ-033: wb_rst_i asserted during EXEC -> all outputs 0 next cycle, no la_ack_o/done afterwards.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between a Wishbone register
// block and a logic-analyzer requester, one job per IDLE->EXEC->CAPT pass.
module alu_arbiter #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        la_req_i,
    input  logic [3:0]  la_op_i,
    input  logic [31:0] la_a_i,
    input  logic [31:0] la_b_i,
    output logic        la_ack_o,
    output logic [31:0] la_result_o,
    output logic [3:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic [31:0] alu_y_i,
    output logic        irq_o
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT} state_t;
    state_t state, state_nxt;
    logic [31:0] a_reg, b_reg, result, rdata;
    logic [3:0]  cmd_op;
    logic [7:0]  off;
    logic        wb_pend, done, ovf, irq_en, job_wb, last_wb;
    logic        acc, wr, cmd_wr, st_wr, wb_run, la_run, busy, la_elig, gnt_wb, gnt_la, capt;
    assign off     = wbs_adr_i[7:0];
    assign acc     = (wbs_adr_i[31:8] == BASE_ADR[31:8]) & wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr      = acc & wbs_we_i;
    assign cmd_wr  = wr & (off == 8'h08) & wbs_sel_i[0];
    assign st_wr   = wr & (off == 8'h10) & wbs_sel_i[0];
    assign wb_run  = (state != IDLE) & job_wb;
    assign la_run  = (state != IDLE) & ~job_wb;
    assign busy    = wb_pend | wb_run;
    assign la_elig = la_req_i & ~la_ack_o & ~la_run;
    // last_wb low means the LA side was served last, so a tie goes to WB
    assign gnt_wb  = (state == IDLE) & wb_pend & (~la_elig | ~last_wb);
    assign gnt_la  = (state == IDLE) & la_elig & (~wb_pend | last_wb);
    assign capt    = (state == CAPT);
    assign irq_o   = done & irq_en;
    assign rdata   = off == 8'h00 ? a_reg :
                     off == 8'h04 ? b_reg :
                     off == 8'h08 ? {28'h0, cmd_op} :
                     off == 8'h0C ? result :
                     off == 8'h10 ? {28'h0, irq_en, ovf, done, busy} : 32'h0;
    always_comb begin
        state_nxt = state == IDLE ? ((gnt_wb | gnt_la) ? EXEC : IDLE) :
                    state == EXEC ? CAPT : IDLE;
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            cmd_op      <= '0;
            result      <= '0;
            la_result_o <= '0;
            alu_op_o    <= '0;
            alu_a_o     <= '0;
            alu_b_o     <= '0;
            wb_pend     <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            irq_en      <= 1'b0;
            job_wb      <= 1'b0;
            last_wb     <= 1'b0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            la_ack_o    <= 1'b0;
        end else begin
            state     <= state_nxt;
            wbs_ack_o <= acc;
            wbs_dat_o <= (acc & ~wbs_we_i) ? rdata : 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (wr && off == 8'h00 && wbs_sel_i[i]) a_reg[8*i +: 8] <= wbs_dat_i[8*i +: 8];
                if (wr && off == 8'h04 && wbs_sel_i[i]) b_reg[8*i +: 8] <= wbs_dat_i[8*i +: 8];
            end
            if (cmd_wr) begin
                if (busy) begin
                    ovf <= 1'b1;
                end else begin
                    wb_pend <= 1'b1;
                    done    <= 1'b0;
                    cmd_op  <= wbs_dat_i[3:0];
                end
            end
            if (st_wr) begin
                if (wbs_dat_i[1]) done <= 1'b0;
                if (wbs_dat_i[2]) ovf <= 1'b0;
                irq_en <= wbs_dat_i[3];
            end
            if (gnt_wb | gnt_la) begin
                alu_op_o <= gnt_wb ? cmd_op : la_op_i;
                alu_a_o  <= gnt_wb ? a_reg : la_a_i;
                alu_b_o  <= gnt_wb ? b_reg : la_b_i;
                job_wb   <= gnt_wb;
                last_wb  <= gnt_wb;
            end
            if (gnt_wb) wb_pend <= 1'b0;
            la_ack_o <= capt & ~job_wb;
            // capture is last so a same-cycle done W1C loses
            if (capt & job_wb) begin
                result <= alu_y_i;
                done   <= 1'b1;
            end
            if (capt & ~job_wb) la_result_o <= alu_y_i;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized register/LA traffic against a behavioural model of
// the register file, the ALU and the arbitration timing rules.
module tb_alu_arbiter;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] R_A = BASE + 32'h00, R_B = BASE + 32'h04, R_CMD = BASE + 32'h08;
    localparam logic [31:0] R_RES = BASE + 32'h0C, R_ST = BASE + 32'h10;
    logic        wb_clk_i = 1'b0, wb_rst_i = 1'b0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o, la_ack_o, irq_o;
    logic [31:0] wbs_dat_o, la_result_o, alu_a_o, alu_b_o, alu_y_i;
    logic        la_req_i = 1'b0;
    logic [3:0]  la_op_i = '0, alu_op_o;
    logic [31:0] la_a_i = '0, la_b_i = '0;
    int errors = 0, checks = 0, la_acks = 0;
    logic [31:0] a_m, b_m;

    alu_arbiter #(.BASE_ADR(BASE)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .la_req_i(la_req_i), .la_op_i(la_op_i), .la_a_i(la_a_i), .la_b_i(la_b_i),
        .la_ack_o(la_ack_o), .la_result_o(la_result_o),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_y_i(alu_y_i),
        .irq_o(irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_y_i = alu_fn(alu_op_o, alu_a_o, alu_b_o);

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    always @(negedge wb_clk_i) if (la_ack_o) la_acks++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge wb_clk_i);
    endtask

    task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rd);
        int n;
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        for (n = 0; n < 8 && !wbs_ack_o; n++) @(negedge wb_clk_i);
        if (n == 8) check("ack_timeout", 32'd0, 32'd1);
        rd = wbs_dat_o;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d;
        wb_cycle(1'b1, adr, dat, sel, d);
    endtask

    task automatic wb_rd(input logic [31:0] adr, output logic [31:0] d);
        wb_cycle(1'b0, adr, 32'h0, 4'hF, d);
    endtask

    task automatic do_reset();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        tick(2);
        wb_rst_i = 1'b0;
        a_m = '0; b_m = '0;
    endtask

    task automatic tie_run(input bit wb_first);
        logic [31:0] d, la_a, la_b;
        logic [3:0]  op1, op4;
        int t_irq = 0, t_ack = 0;
        wb_wr(R_ST, 32'hA, 4'h1);
        a_m = $urandom; b_m = $urandom; la_a = $urandom; la_b = $urandom;
        wb_wr(R_A, a_m, 4'hF);
        wb_wr(R_B, b_m, 4'hF);
        wb_wr(R_CMD, 32'h2, 4'h1);
        la_req_i = 1'b1; la_op_i = 4'd1; la_a_i = la_a; la_b_i = la_b;
        for (int c = 1; c <= 10; c++) begin
            @(negedge wb_clk_i);
            if (c == 1) op1 = alu_op_o;
            if (c == 4) op4 = alu_op_o;
            if (irq_o && t_irq == 0) t_irq = c;
            if (la_ack_o && t_ack == 0) begin t_ack = c; la_req_i = 1'b0; end
        end
        la_req_i = 1'b0;
        check("tie_first_op", {28'h0, op1}, wb_first ? 32'd2 : 32'd1);
        check("tie_second_op", {28'h0, op4}, wb_first ? 32'd1 : 32'd2);
        check("tie_wb_done_cycle", t_irq, wb_first ? 32'd3 : 32'd6);
        check("tie_la_ack_cycle", t_ack, wb_first ? 32'd6 : 32'd3);
        check("tie_la_result", la_result_o, alu_fn(4'd1, la_a, la_b));
        wb_rd(R_RES, d);
        check("tie_wb_result", d, alu_fn(4'd2, a_m, b_m));
    endtask

    initial begin
        logic [31:0] d, da, db, la_a, la_b;
        logic [3:0]  sa, sb, op;
        int n, acks_before, consec;
        bit prev;
        do_reset();
        check("rst_alu_op", {28'h0, alu_op_o}, 32'h0);
        check("rst_alu_a", alu_a_o, 32'h0);
        check("rst_alu_b", alu_b_o, 32'h0);
        check("rst_la_result", la_result_o, 32'h0);
        check("rst_outs", {29'h0, wbs_ack_o, la_ack_o, irq_o}, 32'h0);
        wb_rd(R_ST, d);     check("rst_status", d, 32'h0);
        wb_rd(R_A, d);      check("rst_a", d, 32'h0);
        wb_rd(R_RES, d);    check("rst_result", d, 32'h0);

        wb_wr(R_A, 32'd5, 4'hF);
        wb_wr(R_B, 32'd3, 4'hF);
        wb_wr(R_CMD, 32'h0, 4'h1);
        tick(5);
        a_m = 32'd5; b_m = 32'd3;
        wb_rd(R_RES, d);    check("add_result", d, 32'd8);
        wb_rd(R_ST, d);     check("add_status", d, 32'h2);
        check("add_alu_a", alu_a_o, 32'd5);
        check("add_alu_b", alu_b_o, 32'd3);

        for (int i = 0; i < 6; i++) begin
            da = $urandom; db = $urandom;
            sa = 4'($urandom_range(1, 15)); sb = 4'($urandom_range(1, 15));
            op = 4'($urandom_range(0, 4));
            wb_wr(R_A, da, sa); a_m = merge(a_m, da, sa);
            wb_wr(R_B, db, sb); b_m = merge(b_m, db, sb);
            wb_wr(R_CMD, ($urandom & 32'hFFFF_FFF0) | {28'h0, op}, 4'h1);
            tick(5);
            wb_rd(R_A, d);   check("rand_a", d, a_m);
            wb_rd(R_B, d);   check("rand_b", d, b_m);
            wb_rd(R_CMD, d); check("rand_cmd", d, {28'h0, op});
            wb_rd(R_RES, d); check("rand_result", d, alu_fn(op, a_m, b_m));
        end

        wb_wr(BASE + 32'h14, $urandom, 4'hF);
        wb_rd(BASE + 32'h14, d); check("unmapped_read", d, 32'h0);
        wb_wr(R_CMD, 32'h3, 4'h2);
        wb_rd(R_CMD, d);         check("cmd_sel0_ignored", d, {28'h0, op});

        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_adr_i = BASE ^ 32'h0100_0000;
        n = 0;
        for (int c = 0; c < 4; c++) begin @(negedge wb_clk_i); if (wbs_ack_o) n++; end
        check("undecoded_acks", n, 32'd0);
        wbs_adr_i = R_A; n = 0; consec = 0; prev = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) n++;
            if (wbs_ack_o && prev) consec++;
            prev = wbs_ack_o;
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        check("held_stb_acks", n, 32'd3);
        check("ack_consecutive", consec, 32'd0);
        tick(1);

        la_a = $urandom; la_b = $urandom;
        acks_before = la_acks;
        la_req_i = 1'b1; la_op_i = 4'd1; la_a_i = la_a; la_b_i = la_b;
        for (n = 1; n <= 8 && !la_ack_o; n++) @(negedge wb_clk_i);
        check("la_ack_latency", n, 32'd4);
        check("la_result", la_result_o, alu_fn(4'd1, la_a, la_b));
        tick(1);
        check("la_ack_pulse", {31'h0, la_ack_o}, 32'h0);
        la_req_i = 1'b0;
        tick(5);
        check("la_single_grant", la_acks - acks_before, 32'd1);

        do_reset();
        tie_run(1'b1);
        wb_wr(R_CMD, 32'h0, 4'h1);
        tick(5);
        tie_run(1'b0);

        wb_wr(R_ST, 32'h6, 4'h1);
        da = $urandom; db = $urandom;
        wb_wr(R_A, da, 4'hF);
        wb_wr(R_B, db, 4'hF);
        wb_wr(R_CMD, 32'h1, 4'h1);
        wb_wr(R_CMD, 32'h4, 4'h1);
        tick(5);
        wb_rd(R_ST, d);   check("ovf_status", d, 32'h6);
        wb_rd(R_RES, d);  check("ovf_result", d, alu_fn(4'd1, da, db));
        wb_rd(R_CMD, d);  check("ovf_cmd", d, 32'h1);
        wb_wr(R_ST, 32'h4, 4'h1);
        wb_rd(R_ST, d);   check("ovf_w1c", d, 32'h2);

        wb_wr(R_ST, 32'hA, 4'h1);
        wb_wr(R_CMD, 32'h3, 4'h1);
        tick(5);
        check("irq_set", {31'h0, irq_o}, 32'h1);
        wb_wr(R_ST, 32'hA, 4'h1);
        check("irq_clear", {31'h0, irq_o}, 32'h0);

        la_a = $urandom | 32'h1;
        acks_before = la_acks;
        la_req_i = 1'b1; la_op_i = 4'd3; la_a_i = la_a; la_b_i = $urandom;
        tick(1);
        wb_rst_i = 1'b1; la_req_i = 1'b0;
        tick(1);
        check("rstjob_alu", {28'h0, alu_op_o} | alu_a_o | alu_b_o, 32'h0);
        check("rstjob_la_result", la_result_o, 32'h0);
        check("rstjob_outs", {29'h0, wbs_ack_o, la_ack_o, irq_o}, 32'h0);
        wb_rst_i = 1'b0;
        tick(6);
        check("rstjob_no_ack", la_acks - acks_before, 32'd0);
        wb_rd(R_ST, d);   check("rstjob_status", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
